// File: rtl/vliw_scoreboard_fwd.sv
// VLIW issue scoreboard with per-register latency countdown and writeback-bus forward selection.
// Optional stall performance counter is built when SB_PERF_CNT_EN is defined.
module vliw_scoreboard_fwd #(
  parameter int LANES = 2,
  parameter int AW    = 3,
  parameter int LAT_W = 3,
  localparam int SELW = $clog2(LANES + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  input  logic                     flush,
  input  logic [LANES*2*AW-1:0]    src_addr,
  input  logic [LANES*AW-1:0]      dst_addr,
  input  logic [LANES-1:0]         dst_we,
  input  logic [LANES*LAT_W-1:0]   dst_lat,
  output logic                     stall,
  output logic [LANES*2*SELW-1:0]  fwd_sel,
  output logic                     waw_conflict,
  output logic [15:0]              stall_cycles
);

  localparam int NREG = 1 << AW;
  localparam int OWNW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LAT_W-1:0] cnt [NREG];
  logic [OWNW-1:0]  own [NREG];

  logic [AW-1:0]    src_a   [LANES*2];
  logic [AW-1:0]    dst_a   [LANES];
  logic [LAT_W-1:0] eff_lat [LANES];
  logic [LANES-1:0] lane_wr;
  logic             src_unres;
  logic             order_hazard;
  logic             accept;

  logic [NREG-1:0]  wr_hit;
  logic [LAT_W-1:0] wr_lat [NREG];
  logic [OWNW-1:0]  wr_own [NREG];

  // Decode the bundle fields; a zero latency still completes one cycle later.
  always_comb begin
    for (int i = 0; i < LANES*2; i++) begin
      src_a[i] = src_addr[i*AW +: AW];
    end
    for (int l = 0; l < LANES; l++) begin
      dst_a[l]   = dst_addr[l*AW +: AW];
      eff_lat[l] = (dst_lat[l*LAT_W +: LAT_W] == '0) ? LAT_W'(1) : dst_lat[l*LAT_W +: LAT_W];
      lane_wr[l] = dst_we[l] && (dst_a[l] != '0);
    end
  end

  // Sources look only at pre-bundle state, so same-bundle producers are invisible here.
  always_comb begin
    fwd_sel   = '0;
    src_unres = 1'b0;
    for (int i = 0; i < LANES*2; i++) begin
      if (src_a[i] != '0) begin
        if (cnt[src_a[i]] == LAT_W'(1)) begin
          fwd_sel[i*SELW +: SELW] = SELW'(own[src_a[i]]) + SELW'(1);
        end else if (cnt[src_a[i]] != '0) begin
          src_unres = 1'b1;
        end
      end
    end
  end

  // A younger write must not land before an older pending write to the same register.
  always_comb begin
    order_hazard = 1'b0;
    waw_conflict = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (lane_wr[l] && (eff_lat[l] < cnt[dst_a[l]])) begin
        order_hazard = 1'b1;
      end
      for (int m = l + 1; m < LANES; m++) begin
        if (lane_wr[l] && lane_wr[m] && (dst_a[l] == dst_a[m])) begin
          waw_conflict = 1'b1;
        end
      end
    end
  end

  assign stall  = issue_valid && !flush && (src_unres || order_hazard);
  assign accept = issue_valid && !flush && !stall;

  // Ascending lane order lets the highest-numbered writer win a same-bundle WAW.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      wr_hit[r] = 1'b0;
      wr_lat[r] = '0;
      wr_own[r] = '0;
      for (int l = 0; l < LANES; l++) begin
        if (lane_wr[l] && (int'(dst_a[l]) == r)) begin
          wr_hit[r] = 1'b1;
          wr_lat[r] = eff_lat[l];
          wr_own[r] = OWNW'(l);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
        own[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (accept && wr_hit[r]) begin
          cnt[r] <= wr_lat[r];
          own[r] <= wr_own[r];
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - LAT_W'(1);
        end
      end
    end
  end

`ifdef SB_PERF_CNT_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (stall && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign stall_cycles = perf_q;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule
